// File: rtl/cobra_core_pipe.sv
// cobra_core_pipe: single-issue sequencer core with handshaked I/O,
// a 1-deep output buffer, relative branches and a halt state.

module ALU_RiscV #(
  parameter int W = 32
) (
  input  logic [4:0]   operation,
  input  logic [W-1:0] operand_A,
  input  logic [W-1:0] operand_B,
  output logic [W-1:0] result,
  output logic         flag
);
  localparam int SW = $clog2(W);

  logic [SW-1:0] sh;
  logic          lt_s;
  logic          lt_u;

  assign sh   = operand_B[SW-1:0];
  assign lt_s = $signed(operand_A) < $signed(operand_B);
  assign lt_u = operand_A < operand_B;

  always_comb begin
    result = '0;
    flag   = 1'b0;
    case (operation)
      5'b00000: result = operand_A + operand_B;
      5'b01000: result = operand_A - operand_B;
      5'b00001: result = operand_A << sh;
      5'b00010: result = {{(W-1){1'b0}}, lt_s};
      5'b00011: result = {{(W-1){1'b0}}, lt_u};
      5'b00100: result = operand_A ^ operand_B;
      5'b00101: result = operand_A >> sh;
      5'b01101: result = $unsigned($signed(operand_A) >>> sh);
      5'b00110: result = operand_A | operand_B;
      5'b00111: result = operand_A & operand_B;
      5'b11000: flag = operand_A == operand_B;
      5'b11001: flag = operand_A != operand_B;
      5'b11100: flag = lt_s;
      5'b11101: flag = !lt_s;
      5'b11110: flag = lt_u;
      5'b11111: flag = !lt_u;
      default:  result = '0;
    endcase
  end
endmodule

module cobra_core_pipe #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 8,
  parameter int RF_ZERO = 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            halted,
  output logic [31:0]     instret
);
  typedef enum logic {RUN, HALT} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     instret_q, instret_d;
  logic [XLEN-1:0] rf_q [32];

  logic            b_f, c_f;
  logic [1:0]      ws;
  logic [4:0]      op, ra1, ra2, wa;
  logic [7:0]      off;

  assign {b_f, c_f, ws, op, ra1, ra2, off, wa} = imem_rdata;

  logic [XLEN-1:0] rd1, rd2, alu_res, k_val, wr_data;
  logic            alu_flag;

  assign rd1 = (RF_ZERO != 0 && ra1 == 5'd0) ? '0 : rf_q[ra1];
  assign rd2 = (RF_ZERO != 0 && ra2 == 5'd0) ? '0 : rf_q[ra2];
  assign k_val = {{(XLEN-23){imem_rdata[27]}}, imem_rdata[27:5]};

  ALU_RiscV #(.W(XLEN)) u_alu (
    .operation (op),
    .operand_A (rd1),
    .operand_B (rd2),
    .result    (alu_res),
    .flag      (alu_flag)
  );

  logic run, need_in, need_out, out_busy;
  logic stall, retire, taken, do_halt, wr_en;
  logic [PC_W-1:0] off_ext;

  assign run      = state_q == RUN;
  assign need_in  = ws == 2'b01;
  assign need_out = b_f & c_f;
  assign out_busy = out_valid_q & !out_ready;
  assign stall    = (need_in & !in_valid) | (need_out & out_busy);
  assign retire   = run & !stall;
  assign in_ready = !reset & run & need_in & !(need_out & out_busy);

  // Offset is 8-bit two's complement; the cast widens or truncates to PC_W.
  assign off_ext = PC_W'($signed(off));
  assign taken   = (!b_f & c_f & alu_flag) | (b_f & !c_f);
  assign do_halt = retire & b_f & !c_f & (off == 8'd0);
  assign wr_en   = retire & (ws != 2'b00)
                 & !(RF_ZERO != 0 && wa == 5'd0);

  always_comb begin
    wr_data = alu_res;
    unique case (ws)
      2'b01:   wr_data = in_data;
      2'b10:   wr_data = k_val;
      default: wr_data = alu_res;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instret_d   = instret_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & !out_ready;
    if (retire) begin
      pc_d      = taken ? pc_q + off_ext : pc_q + 1'b1;
      instret_d = instret_q + 32'd1;
      if (need_out) begin
        out_data_d  = rd1;
        out_valid_d = 1'b1;
      end
      if (do_halt) state_d = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= '0;
      instret_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instret_q   <= instret_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      if (wr_en) rf_q[wa] <= wr_data;
    end
  end

  assign imem_addr = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = state_q == HALT;
  assign instret   = instret_q;
endmodule

// File: tb/tb_cobra_core_pipe.sv
// Bench for cobra_core_pipe: ISA-level model compared every cycle,
// plus directed programs with hand-computed checkpoints.

module tb_cobra_core_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        halted;
  logic [31:0] instret;

  logic [31:0] imem [256];
  assign imem_rdata = imem[imem_addr];

  cobra_core_pipe #(.XLEN(32), .PC_W(8), .RF_ZERO(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .halted     (halted),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_EQ  = 5'b11000;
  localparam logic [4:0] OP_NE  = 5'b11001;

  function automatic logic [31:0] enc(input logic [1:0] bc,
    input logic [1:0] ws, input logic [4:0] op, input logic [4:0] ra1,
    input logic [4:0] ra2, input logic [7:0] off, input logic [4:0] wa);
    return {bc, ws, op, ra1, ra2, off, wa};
  endfunction

  function automatic logic [31:0] kconst(input logic [22:0] v,
                                         input logic [4:0] wa);
    return {2'b00, 2'b10, v, wa};
  endfunction

  // ---- ISA-level reference model ----
  logic [7:0]  m_pc;
  logic [31:0] m_rf [32];
  logic        m_ov, m_halt;
  logic [31:0] m_od, m_instret;
  bit          m_init = 0;

  function automatic logic [31:0] rd(input logic [4:0] i);
    return (i == 0) ? 32'd0 : m_rf[i];
  endfunction

  function automatic logic [32:0] alu(input logic [4:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      5'b00000: return {1'b0, a + b};
      5'b01000: return {1'b0, a - b};
      5'b00100: return {1'b0, a ^ b};
      5'b00110: return {1'b0, a | b};
      5'b00111: return {1'b0, a & b};
      5'b11000: return {a == b, 32'd0};
      5'b11001: return {a != b, 32'd0};
      default:  return 33'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] ins, a, b, r;
    logic [1:0]  bc, ws;
    logic        fl, go;
    logic [32:0] ar;
    m_init = 1;
    if (reset) begin
      m_pc = 0; m_ov = 0; m_od = 0; m_halt = 0; m_instret = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      ins = imem[m_pc];
      bc = ins[31:30];
      ws = ins[29:28];
      a = rd(ins[22:18]);
      b = rd(ins[17:13]);
      ar = alu(ins[27:23], a, b);
      fl = ar[32];
      r = ar[31:0];
      go = !m_halt && (ws != 1 || in_valid)
           && (bc != 3 || !m_ov || out_ready);
      if (m_ov && out_ready) m_ov = 0;
      if (go) begin
        if (ins[4:0] != 0) begin
          if (ws == 1) m_rf[ins[4:0]] = in_data;
          if (ws == 2) m_rf[ins[4:0]] = {{9{ins[27]}}, ins[27:5]};
          if (ws == 3) m_rf[ins[4:0]] = r;
        end
        if (bc == 2 || (bc == 1 && fl)) m_pc = m_pc + ins[12:5];
        else m_pc = m_pc + 1;
        if (bc == 2 && ins[12:5] == 0) m_halt = 1;
        if (bc == 3) begin
          m_ov = 1;
          m_od = a;
        end
        m_instret = m_instret + 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] ins;
    logic        e_rdy;
    if (m_init) begin
      ins = imem[m_pc];
      e_rdy = !reset && !m_halt && ins[29:28] == 1
              && !(ins[31:30] == 3 && m_ov && !out_ready);
      chk("pc", {24'd0, imem_addr}, {24'd0, m_pc});
      chk("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      chk("out_data", out_data, m_od);
      chk("halted", {31'd0, halted}, {31'd0, m_halt});
      chk("instret", instret, m_instret);
    end
  end

  // ---- directed stimulus ----
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  logic [31:0] HLT;

  initial begin
    HLT = enc(2'b10, 2'b00, 5'd0, 5'd0, 5'd0, 8'd0, 5'd0);
    clr_mem();

    // Program 1: const/ALU, input stall, output backpressure, halt
    imem[0] = kconst(23'h7FFFFF, 5'd1);
    imem[1] = enc(2'b00, 2'b11, OP_ADD, 5'd1, 5'd1, 8'd0, 5'd2);
    imem[2] = enc(2'b00, 2'b01, 5'd0, 5'd0, 5'd0, 8'd0, 5'd3);
    imem[3] = kconst(23'hA, 5'd4);
    imem[4] = kconst(23'hB, 5'd5);
    imem[5] = enc(2'b11, 2'b00, 5'd0, 5'd4, 5'd0, 8'd0, 5'd0);
    imem[6] = enc(2'b11, 2'b00, 5'd0, 5'd5, 5'd0, 8'd0, 5'd0);
    imem[7] = enc(2'b11, 2'b00, 5'd0, 5'd3, 5'd0, 8'd0, 5'd0);
    imem[8] = enc(2'b11, 2'b00, 5'd0, 5'd2, 5'd0, 8'd0, 5'd0);
    imem[9] = HLT;
    do_reset();
    mid();
    chk("rst_pc", {24'd0, imem_addr}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    nxt();
    nxt();
    mid();
    chk("alu_instret", instret, 32'd2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        nxt();
        mid();
      end
      chk("in_stall_pc", {24'd0, imem_addr}, 32'd2);
      chk("in_stall_rdy", {31'd0, in_ready}, 32'd1);
    end
    nxt();
    in_data = 32'h1234;
    in_valid = 1'b1;
    mid();
    chk("in_go_rdy", {31'd0, in_ready}, 32'd1);
    nxt();
    in_valid = 1'b0;
    in_data = '0;
    mid();
    chk("in_pc_adv", {24'd0, imem_addr}, 32'd3);
    nxt();
    nxt();
    nxt();
    mid();
    chk("out1_pc", {24'd0, imem_addr}, 32'd6);
    chk("out1_data", out_data, 32'hA);
    chk("out1_valid", {31'd0, out_valid}, 32'd1);
    nxt();
    nxt();
    mid();
    chk("out_stall_pc", {24'd0, imem_addr}, 32'd6);
    nxt();
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;
    mid();
    chk("refill_data", out_data, 32'hB);
    chk("refill_valid", {31'd0, out_valid}, 32'd1);
    chk("refill_pc", {24'd0, imem_addr}, 32'd7);
    nxt();
    out_ready = 1'b1;
    repeat (5) nxt();
    mid();
    chk("p1_halted", {31'd0, halted}, 32'd1);
    chk("p1_pc", {24'd0, imem_addr}, 32'd9);
    chk("p1_instret", instret, 32'd10);
    chk("p1_data", out_data, 32'hFFFF_FFFE);
    chk("p1_ov", {31'd0, out_valid}, 32'd0);

    // Program 2: branch wrap, taken and not-taken
    clr_mem();
    imem[0]   = enc(2'b00, 2'b01, 5'd0, 5'd0, 5'd0, 8'd0, 5'd1);
    imem[2]   = enc(2'b01, 2'b00, OP_EQ, 5'd1, 5'd0, 8'hFC, 5'd0);
    imem[3]   = HLT;
    imem[254] = enc(2'b01, 2'b00, OP_NE, 5'd0, 5'd0, 8'h10, 5'd0);
    imem[255] = enc(2'b10, 2'b00, 5'd0, 5'd0, 5'd0, 8'h01, 5'd0);
    in_valid = 1'b1;
    in_data = 32'd0;
    do_reset();
    nxt();
    nxt();
    mid();
    chk("br_pc2", {24'd0, imem_addr}, 32'd2);
    nxt();
    mid();
    chk("br_taken", {24'd0, imem_addr}, 32'hFE);
    nxt();
    mid();
    chk("br_ntaken", {24'd0, imem_addr}, 32'hFF);
    nxt();
    mid();
    chk("jmp_wrap", {24'd0, imem_addr}, 32'h00);
    in_data = 32'd5;
    nxt();
    nxt();
    nxt();
    mid();
    chk("br2_ntaken", {24'd0, imem_addr}, 32'd3);
    nxt();
    mid();
    chk("p2_halted", {31'd0, halted}, 32'd1);
    chk("p2_instret", instret, 32'd9);
    in_valid = 1'b0;
    in_data = '0;

    // Program 3: halt freezes core, buffer still drains, reset exits
    clr_mem();
    imem[0] = kconst(23'h55, 5'd1);
    imem[1] = enc(2'b11, 2'b00, 5'd0, 5'd1, 5'd0, 8'd0, 5'd0);
    imem[5] = HLT;
    out_ready = 1'b0;
    do_reset();
    repeat (6) nxt();
    mid();
    chk("h_halted", {31'd0, halted}, 32'd1);
    chk("h_pc", {24'd0, imem_addr}, 32'd5);
    chk("h_instret", instret, 32'd6);
    chk("h_ov", {31'd0, out_valid}, 32'd1);
    repeat (20) nxt();
    mid();
    chk("h_pc_frozen", {24'd0, imem_addr}, 32'd5);
    chk("h_ir_frozen", instret, 32'd6);
    nxt();
    out_ready = 1'b1;
    nxt();
    mid();
    chk("h_drained", {31'd0, out_valid}, 32'd0);
    chk("h_data", out_data, 32'h55);
    reset = 1'b1;
    nxt();
    mid();
    chk("h_rst_pc", {24'd0, imem_addr}, 32'd0);
    chk("h_rst_halted", {31'd0, halted}, 32'd0);

    // Program 4: reset mid-stall, then x0 write discarded
    clr_mem();
    imem[0] = kconst(23'h99, 5'd0);
    imem[1] = kconst(23'h7, 5'd1);
    imem[2] = enc(2'b11, 2'b00, 5'd0, 5'd1, 5'd0, 8'd0, 5'd0);
    imem[3] = enc(2'b11, 2'b00, 5'd0, 5'd1, 5'd0, 8'd0, 5'd0);
    imem[4] = enc(2'b11, 2'b00, 5'd0, 5'd0, 5'd0, 8'd0, 5'd0);
    imem[5] = HLT;
    out_ready = 1'b0;
    do_reset();
    repeat (3) nxt();
    mid();
    chk("rs_stall_pc", {24'd0, imem_addr}, 32'd3);
    chk("rs_stall_ov", {31'd0, out_valid}, 32'd1);
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    mid();
    chk("rs_ov", {31'd0, out_valid}, 32'd0);
    chk("rs_pc", {24'd0, imem_addr}, 32'd0);
    chk("rs_instret", instret, 32'd0);
    chk("rs_data", out_data, 32'd0);
    out_ready = 1'b1;
    repeat (6) nxt();
    mid();
    chk("x0_data", out_data, 32'd0);
    chk("x0_halted", {31'd0, halted}, 32'd1);
    chk("x0_instret", instret, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cobra_core_pipe.md
Name: cobra_core_pipe

Overview:
Parametrised single-issue sequencer core. Executes one 32-bit instruction per cycle from an external, combinationally-read instruction memory, and adds the following:
- valid/ready handshakes on the input and output data ports;
- a 1-deep registered output buffer;
- sign-extended relative branches;
- a halt state;
- a retired-instruction counter.

It sits between the program ROM, the existing ALU_RiscV, and the board I/O.

Parameters:
XLEN, 32, data and register width (>=24).
PC_W, 8, program counter width; PC arithmetic wraps modulo 2^PC_W.
RF_ZERO, 1, if 1 register x0 reads 0 and writes to it are discarded.

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
imem_addr  output  PC_W  instruction address, equal to PC
imem_rdata  input  32  instruction at imem_addr, same cycle
in_data  input  XLEN  input word
in_valid  input  1  in_data valid
in_ready  output  1  core consumes in_data this cycle
out_data  output  XLEN  registered output word
out_valid  output  1  out_data pending
out_ready  input  1  sink accepts out_data
halted  output  1  core in HALT state
instret  output  32  retired instruction count

Behaviour:
Instruction fields:
- [31] B
- [30] C
- [29:28] WS
- [27:23] ALU_op
- [22:18] RA1
- [17:13] RA2
- [12:5] OFF
- [4:0] WA

Register file:
- 32 x XLEN, two combinational read ports (RD1 = reg[RA1], RD2 = reg[RA2]) and one synchronous write port.
- All registers clear to 0 on reset.

ALU:
- The existing ALU_RiscV is instantiated with operand_A = RD1, operand_B = RD2, operation = ALU_op.
- Its outputs are result and flag.

Write-back (applied on retire only, to reg[WA]):
- WS=00: no write.
- WS=01: write in_data.
- WS=10: write sign-extend of [27:5] (23 bits) to XLEN.
- WS=11: write ALU result.

Instruction classes by {B,C}:
- 00: plain; next PC = PC+1.
- 01: conditional branch; next PC = PC + sext(OFF) if flag, else PC+1.
- 10: unconditional jump; next PC = PC + sext(OFF).
- 11: OUT; next PC = PC+1; RD1 is loaded into the output buffer.
- OFF is 8-bit two's complement, sign-extended to PC_W (or truncated if PC_W<8). The sum wraps.

States: RUN and HALT. Reset enters RUN.

Stall rules in RUN (an instruction retires in the cycle its stall conditions are false):
- need_in = (WS==01); stall if need_in & !in_valid.
- need_out = ({B,C}==11); stall if need_out & out_valid & !out_ready.
- Either stall active: PC holds, no register write, output buffer unchanged, instret holds.
- IN and OUT in the same instruction: retires only when both conditions clear.

in_ready:
- Combinational: in_ready = RUN & need_in & !(need_out & out_valid & !out_ready).
- in_data is consumed exactly when in_valid & in_ready.
- in_ready never asserts in HALT or during reset.

Output buffer:
- out_valid clears in the cycle out_valid & out_ready.
- When an OUT retires: out_data <= RD1 and out_valid <= 1 on the next edge. A simultaneous drain and refill leaves out_valid=1 holding the new data (no bubble).
- out_data holds its value after it is drained.

Halt:
- A retiring {B,C}=10 with OFF=0 moves the core to HALT on the next edge.
- In HALT:
  - PC is frozen and no register writes occur.
  - halted=1 and instret stops.
  - The output buffer still drains.
- Only reset leaves HALT.

instret:
- Increments by 1 on every retire, including the halting jump.
- Wraps at 2^32.

Reset values:
- PC=0, state=RUN, halted=0, out_valid=0, out_data=0, instret=0.
- Reset asserted mid-stall discards the pending instruction and drops the output buffer contents.

x0:
- With RF_ZERO=1, reads of x0 return 0 and writes to x0 are discarded.
- With RF_ZERO=0, x0 is an ordinary register.

Test Plan:
- Const/ALU: WS=10 with [27:5]=0x7FFFFF into x1 -> x1=0xFFFFFFFF; ALU add x1+x1 into x2 -> x2=0xFFFFFFFE; instret=2.
- Input stall: IN to x3 with in_valid=0 for 5 cycles, then in_data=0x1234 valid -> PC held 5 cycles with in_ready=1; x3=0x1234; PC advances exactly once.
- Output backpressure: two back-to-back OUTs of 0xA then 0xB with out_ready=0 -> first sets out_valid=1/out_data=0xA, second stalls. Raising out_ready for 1 cycle -> out_data=0xB, out_valid=1 with no gap.
- Branch wrap: PC=2, conditional branch taken with OFF=0xFC -> PC=0xFE. Not-taken -> PC=3. Jump from 0xFF with OFF=1 -> PC=0x00.
- Halt: jump with OFF=0 at PC=5 -> halted=1 next cycle; PC stays 5 and instret is frozen for 20 cycles; pending out_valid drains on out_ready; reset -> PC=0, halted=0.
- Reset mid-stall: an OUT stalled on out_ready=0 with reset asserted -> next cycle out_valid=0, PC=0, instret=0; x0 write attempt afterwards reads back 0.
